// File: rtl/decoder_pkg.sv
// decoder_pkg: decoded-instruction bundle, issue FSM state and load-count width.
// Shared by the decoder, issue_ctrl and issue_scoreboard; no ports.
package decoder_pkg;

  localparam int LD_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [4:0] rd;
    logic       r_rs1;
    logic       r_rs2;
    logic       r_rs3;
    logic       w_rd;
    logic       r_cr;
    logic       w_cr;
  } regs_t;

  typedef struct packed {
    regs_t regs;
    logic  mem_r;
    logic  scall;
    logic  eret;
    logic  mtsr;
    logic  mtcr;
    logic  udf;
  } decoded_t;

  function automatic logic is_serial(decoded_t d);
    return d.scall | d.eret | d.mtsr | d.mtcr | d.udf;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: GPR/CR pending-write bits and hazard lookup.
// Ports: clk, rst_n, regs, set_en, wb_valid, wb_rd, wb_cr -> hazard, empty.
module issue_scoreboard
  import decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  regs_t      regs,
  input  logic       set_en,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       wb_cr,
  output logic       hazard,
  output logic       empty
);

  logic [31:1] pend;
  logic        pend_cr;
  logic [31:0] pv;
  logic [31:1] set_m;
  logic [31:1] clr_m;

  // r0 reads as never pending
  assign pv = {pend, 1'b0};

  always_comb begin
    set_m = '0;
    clr_m = '0;
    for (int i = 1; i < 32; i++) begin
      set_m[i] = set_en & regs.w_rd
               & (regs.rd == 5'(i));
      clr_m[i] = wb_valid & (wb_rd == 5'(i));
    end
  end

  // set wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      pend_cr <= 1'b0;
    end else begin
      pend    <= (pend & ~clr_m) | set_m;
      pend_cr <= (pend_cr & ~wb_cr)
               | (set_en & regs.w_cr);
    end
  end

  assign hazard = (regs.r_rs1 & pv[regs.rs1])
                | (regs.r_rs2 & pv[regs.rs2])
                | (regs.r_rs3 & pv[regs.rs3])
                | (regs.w_rd  & pv[regs.rd])
                | ((regs.r_cr | regs.w_cr) & pend_cr);

  assign empty = ~|pend & ~pend_cr;

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue gate with scoreboard, load limit, serialization.
// Ports: id_* in, iss_* out, wb_*/ld_done/ser_done/flush, idle, stall_cycles.
// Optional ISSUE_PERF_EN: stall_cycles counts stalled cycles, else tied 0.
module issue_ctrl
  import decoder_pkg::*;
#(
  parameter int MAX_LD = 4
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  decoded_t    id_dec,
  output logic        id_ready,
  output logic        iss_valid,
  output decoded_t    iss_dec,
  input  logic        iss_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_cr,
  input  logic        ld_done,
  input  logic        ser_done,
  input  logic        flush,
  output logic        idle,
  output logic [31:0] stall_cycles
);

  issue_state_t        state;
  issue_state_t        state_n;
  logic [LD_CNT_W-1:0] ld_cnt;
  logic                hazard;
  logic                sb_empty;
  logic                serial;
  logic                ld_full;
  logic                drained;
  logic                fire_run;
  logic                fire_drain;
  logic                fire;
  logic                ld_inc;
  logic                ld_dec;

  issue_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .regs     (id_dec.regs),
    .set_en   (fire),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_cr    (wb_cr),
    .hazard   (hazard),
    .empty    (sb_empty)
  );

  assign serial  = is_serial(id_dec);
  assign ld_full = id_dec.mem_r
                 & (ld_cnt == LD_CNT_W'(MAX_LD));
  assign drained = sb_empty & (ld_cnt == '0);

  assign fire_run   = (state == ST_RUN)
                    & ~hazard & ~serial & ~ld_full;
  assign fire_drain = (state == ST_DRAIN) & drained;

  // rst_n gate keeps the handshake low while reset is held
  assign fire = rst_n & id_valid & iss_ready & ~flush
              & (fire_run | fire_drain);

  assign id_ready  = fire;
  assign iss_valid = fire;
  assign iss_dec   = id_dec;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_RUN:
        if (id_valid & serial & ~flush)
          state_n = ST_DRAIN;
      ST_DRAIN:
        if (flush)
          state_n = ST_RUN;
        else if (fire)
          state_n = ST_SERIAL;
      ST_SERIAL:
        if (ser_done)
          state_n = ST_RUN;
      default:
        state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_RUN;
    else
      state <= state_n;
  end

  assign ld_inc = fire & id_dec.mem_r;
  assign ld_dec = ld_done & (ld_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= '0;
    end else begin
      unique case ({ld_inc, ld_dec})
        2'b10:   ld_cnt <= ld_cnt + LD_CNT_W'(1);
        2'b01:   ld_cnt <= ld_cnt - LD_CNT_W'(1);
        default: ld_cnt <= ld_cnt;
      endcase
    end
  end

  assign idle = drained & (state == ST_RUN);

`ifdef ISSUE_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (id_valid & ~fire & ~flush)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
